// File: rtl/peripheral_bfm_axi_pkg.sv
// Shared AXI encodings, FSM state type and size helper for the peripheral BFM arbiter.
package peripheral_bfm_axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_WR    = 3'd2,
        ST_RD    = 3'd3,
        ST_RESP  = 3'd4
    } bfm_state_e;

    // AxSIZE encoding for a beat of nbytes bytes
    function automatic logic [2:0] axi_size(input int unsigned nbytes);
        case (nbytes)
            1:       return 3'd0;
            2:       return 3'd1;
            4:       return 3'd2;
            8:       return 3'd3;
            16:      return 3'd4;
            32:      return 3'd5;
            64:      return 3'd6;
            128:     return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/peripheral_bfm_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping around.
module peripheral_bfm_rr_arbiter
    import peripheral_bfm_axi_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int cand;

    // scan NREQ candidates starting at ptr; first hit wins
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = (int'(ptr) + i) % NREQ;
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/peripheral_bfm_arbiter_axi.sv
// Shares one AXI4 master port among NREQ single-beat requesters, one transaction at a time.
module peripheral_bfm_arbiter_axi
    import peripheral_bfm_axi_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*AW-1:0]     req_addr,
    input  logic [NREQ*DW-1:0]     req_wdata,
    input  logic [NREQ*DW/8-1:0]   req_wstrb,
    output logic [NREQ-1:0]        req_ack,
    output logic [DW-1:0]          req_rdata,
    output logic [1:0]             req_resp,
    output logic [3:0]             awid,
    output logic [AW-1:0]          awaddr,
    output logic [3:0]             awlen,
    output logic [2:0]             awsize,
    output logic [1:0]             awburst,
    output logic                   awvalid,
    input  logic                   awready,
    output logic [DW-1:0]          wdata,
    output logic [DW/8-1:0]        wstrb,
    output logic                   wlast,
    output logic                   wvalid,
    input  logic                   wready,
    input  logic [3:0]             bid,
    input  logic [1:0]             bresp,
    input  logic                   bvalid,
    output logic                   bready,
    output logic [3:0]             arid,
    output logic [AW-1:0]          araddr,
    output logic [3:0]             arlen,
    output logic [2:0]             arsize,
    output logic [1:0]             arburst,
    output logic                   arvalid,
    input  logic                   arready,
    input  logic [3:0]             rid,
    input  logic [DW-1:0]          rdata,
    input  logic [1:0]             rresp,
    input  logic                   rlast,
    input  logic                   rvalid,
    output logic                   rready
);

    localparam int         IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int         SW   = DW / 8;
    localparam logic [2:0] SIZE = axi_size(SW);

    bfm_state_e       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d, ptr_q, ptr_d;
    logic [NREQ-1:0]  gnt_q, gnt_d, ack_q, ack_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [SW-1:0]    wstrb_q, wstrb_d;
    logic             awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic             bready_q, bready_d, rready_q, rready_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [1:0]       resp_q, resp_d;
    logic             aw_done, w_done;

    logic [NREQ-1:0]  arb_req, arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             arb_any;

    // IDs are implicit (single outstanding) and rlast is not required on the only beat
    logic             unused_inputs;
    assign unused_inputs = ^{bid, rid, rlast};

    // a requester being acked this cycle is not yet obliged to have dropped req_valid
    assign arb_req = req_valid & ~ack_q;

    peripheral_bfm_rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req (arb_req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // next-state and next-register values; everything holds unless a case below moves it
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        ack_d     = '0;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        bready_d  = bready_q;
        rready_d  = rready_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        aw_done   = 1'b0;
        w_done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    idx_d   = arb_idx;
                    gnt_d   = arb_gnt;
                    we_d    = req_we[arb_idx];
                    addr_d  = req_addr[arb_idx*AW +: AW];
                    wdata_d = req_wdata[arb_idx*DW +: DW];
                    wstrb_d = req_wstrb[arb_idx*SW +: SW];
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (we_q) begin
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = ST_WR;
                end else begin
                    arvalid_d = 1'b1;
                    state_d   = ST_RD;
                end
            end
            ST_WR: begin
                // each channel is done once its valid is gone or is handshaking now
                aw_done = !awvalid_q || awready;
                w_done  = !wvalid_q || wready;
                if (awvalid_q && awready) awvalid_d = 1'b0;
                if (wvalid_q && wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_RD: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (we_q ? (bvalid && bready_q) : (rvalid && rready_q)) begin
                    if (we_q) begin
                        resp_d = bresp;
                    end else begin
                        resp_d  = rresp;
                        rdata_d = rdata;
                    end
                    ack_d    = gnt_q;
                    bready_d = 1'b0;
                    rready_d = 1'b0;
                    ptr_d    = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state, command latch and AXI channel registers; reset abandons any transaction
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            ptr_q     <= '0;
            gnt_q     <= '0;
            ack_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    assign req_ack   = ack_q;
    assign req_rdata = rdata_q;
    assign req_resp  = resp_q;

    assign awid    = 4'(idx_q);
    assign awaddr  = addr_q;
    assign awlen   = 4'd0;
    assign awsize  = SIZE;
    assign awburst = BURST_INCR;
    assign awvalid = awvalid_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;

    assign arid    = 4'(idx_q);
    assign araddr  = addr_q;
    assign arlen   = 4'd0;
    assign arsize  = SIZE;
    assign arburst = BURST_INCR;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;

endmodule

// File: tb/tb_peripheral_bfm_arbiter_axi.sv
// Directed bench for peripheral_bfm_arbiter_axi with a small AXI slave responder.
module tb_peripheral_bfm_arbiter_axi;
    import peripheral_bfm_axi_pkg::*;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;

    logic                 aclk = 1'b0;
    logic                 aresetn;
    logic [NREQ-1:0]      req_valid, req_we, req_ack;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ*SW-1:0]   req_wstrb;
    logic [DW-1:0]        req_rdata;
    logic [1:0]           req_resp;
    logic [3:0]           awid, awlen, arid, arlen, bid, rid;
    logic [AW-1:0]        awaddr, araddr;
    logic [2:0]           awsize, arsize;
    logic [1:0]           awburst, arburst, bresp, rresp;
    logic                 awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic                 arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0]        wdata, rdata;
    logic [SW-1:0]        wstrb;

    // slave configuration and monitor results
    int                   aw_dly, w_dly, ar_dly, aw_wait, w_wait, ar_wait;
    logic [1:0]           b_resp_cfg, r_resp_cfg;
    logic [DW-1:0]        r_data_cfg;
    logic                 r_last_cfg;
    int                   aw_beats, w_beats, ar_beats, ar_stall;
    logic [AW-1:0]        mon_awaddr, mon_araddr;
    logic [DW-1:0]        mon_wdata;
    logic [SW-1:0]        mon_wstrb;
    logic [3:0]           mon_awid, mon_arid;

    int tests = 0;
    int fails = 0;

    always #5 aclk = ~aclk;

    peripheral_bfm_arbiter_axi #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_ack(req_ack), .req_rdata(req_rdata), .req_resp(req_resp),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // slave: readies after a configurable stall, responses answer bready/rready at once
    initial begin
        awready = 0; wready = 0; arready = 0;
        bvalid = 0; bresp = 0; bid = 0;
        rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
        forever begin
            @(negedge aclk);
            if (awvalid) begin awready = (aw_wait >= aw_dly); aw_wait++; end
            else begin awready = 0; aw_wait = 0; end
            if (wvalid) begin wready = (w_wait >= w_dly); w_wait++; end
            else begin wready = 0; w_wait = 0; end
            if (arvalid) begin arready = (ar_wait >= ar_dly); ar_wait++; end
            else begin arready = 0; ar_wait = 0; end
            bvalid = bready;
            bresp  = bready ? b_resp_cfg : 2'b00;
            rvalid = rready;
            rdata  = rready ? r_data_cfg : '0;
            rresp  = rready ? r_resp_cfg : 2'b00;
            rlast  = rready & r_last_cfg;
        end
    end

    // handshake monitor
    initial begin
        forever begin
            @(posedge aclk);
            if (aresetn) begin
                if (awvalid && awready) begin aw_beats++; mon_awaddr = awaddr; mon_awid = awid; end
                if (wvalid && wready)   begin w_beats++; mon_wdata = wdata; mon_wstrb = wstrb; end
                if (arvalid && arready) begin ar_beats++; mon_araddr = araddr; mon_arid = arid; end
                if (arvalid && !arready) ar_stall++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clr_mon();
        aw_beats = 0; w_beats = 0; ar_beats = 0; ar_stall = 0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_wstrb[i*SW +: SW] = s;
    endtask

    task automatic wait_ack(input string tag, output logic [NREQ-1:0] ack,
                            output logic [DW-1:0] rd, output logic [1:0] rs);
        logic found;
        found = 1'b0;
        ack = '0; rd = '0; rs = '0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge aclk);
            if (|req_ack) begin
                found = 1'b1;
                ack = req_ack; rd = req_rdata; rs = req_resp;
            end
        end
        check({tag, "_ack_seen"}, 64'(found), 64'd1);
    endtask

    initial begin
        logic [NREQ-1:0] ack;
        logic [DW-1:0]   rd;
        logic [1:0]      rs;
        logic            seen, any_ack;
        int              ord[5] = '{0, 1, 2, 3, 0};

        aresetn = 0;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        aw_dly = 0; w_dly = 0; ar_dly = 0;
        b_resp_cfg = RESP_OKAY; r_resp_cfg = RESP_OKAY; r_data_cfg = '0; r_last_cfg = 1'b1;
        mon_awaddr = '0; mon_araddr = '0; mon_wdata = '0; mon_wstrb = '0; mon_awid = '0; mon_arid = '0;
        clr_mon();

        repeat (3) @(negedge aclk);
        check("rst_outputs", {awvalid, wvalid, arvalid, bready, rready, req_ack, req_resp}, '0);
        aresetn = 1;
        @(negedge aclk);

        // single write from requester 0, slave always ready
        clr_mon();
        set_req(0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
        @(negedge aclk);
        check("t1_no_valid_yet", {awvalid, wvalid}, 2'b00);
        @(negedge aclk);
        check("t1_aw_w_valid", {awvalid, wvalid}, 2'b11);
        check("t1_awaddr", awaddr, 32'h0000_1000);
        check("t1_wdata", wdata, 32'hDEAD_BEEF);
        check("t1_wstrb", wstrb, 4'hF);
        check("t1_awid", awid, 4'd0);
        check("t1_aw_const", {awlen, awsize, awburst, wlast}, {4'd0, 3'd2, 2'b01, 1'b1});
        wait_ack("t1", ack, rd, rs);
        req_valid[0] = 1'b0;
        check("t1_ack", ack, 4'b0001);
        check("t1_resp", rs, 2'b00);
        check("t1_beats", {8'(aw_beats), 8'(w_beats)}, {8'd1, 8'd1});

        // read from requester 2 with a 3-cycle arready stall
        clr_mon();
        ar_dly = 3; r_data_cfg = 32'h1234_5678;
        set_req(2, 1'b0, 32'h0000_2004, '0, '0);
        wait_ack("t2", ack, rd, rs);
        req_valid[2] = 1'b0;
        ar_dly = 0;
        check("t2_ack", ack, 4'b0100);
        check("t2_rdata", rd, 32'h1234_5678);
        check("t2_resp", rs, 2'b00);
        check("t2_ar_stall", ar_stall, 3);
        check("t2_araddr", mon_araddr, 32'h0000_2004);
        check("t2_arid", mon_arid, 4'd2);
        check("t2_ar_const", {arlen, arsize, arburst}, {4'd0, 3'd2, 2'b01});

        // W accepted two cycles ahead of AW, then both in the same cycle
        clr_mon();
        aw_dly = 2; w_dly = 0;
        set_req(3, 1'b1, 32'h0000_3000, 32'hA5A5_A5A5, 4'b0011);
        wait_ack("t4a", ack, rd, rs);
        req_valid[3] = 1'b0;
        check("t4a_ack", ack, 4'b1000);
        check("t4a_beats", {8'(aw_beats), 8'(w_beats)}, {8'd1, 8'd1});
        check("t4a_wstrb", mon_wstrb, 4'b0011);
        check("t4a_awid", mon_awid, 4'd3);
        clr_mon();
        aw_dly = 0;
        set_req(1, 1'b1, 32'h0000_3010, 32'h0BAD_CAFE, 4'hF);
        wait_ack("t4b", ack, rd, rs);
        req_valid[1] = 1'b0;
        check("t4b_ack", ack, 4'b0010);
        check("t4b_beats", {8'(aw_beats), 8'(w_beats)}, {8'd1, 8'd1});
        check("t4b_awaddr", mon_awaddr, 32'h0000_3010);
        check("t4b_wdata", mon_wdata, 32'h0BAD_CAFE);

        // SLVERR passed through, following transaction unaffected
        b_resp_cfg = RESP_SLVERR;
        set_req(2, 1'b1, 32'h0000_4000, 32'h1111_2222, 4'hF);
        wait_ack("t5a", ack, rd, rs);
        req_valid[2] = 1'b0;
        b_resp_cfg = RESP_OKAY;
        check("t5a_ack", ack, 4'b0100);
        check("t5a_resp", rs, 2'b10);
        r_data_cfg = 32'hCAFE_F00D;
        set_req(3, 1'b0, 32'h0000_4004, '0, '0);
        wait_ack("t5b", ack, rd, rs);
        req_valid[3] = 1'b0;
        check("t5b_ack", ack, 4'b1000);
        check("t5b_resp", rs, 2'b00);
        check("t5b_rdata", rd, 32'hCAFE_F00D);

        // all requesters held: rotation 0,1,2,3,0 (reads return rlast=0)
        clr_mon();
        r_last_cfg = 1'b0; r_data_cfg = 32'h5555_AAAA;
        for (int i = 0; i < NREQ; i++)
            set_req(i, (i % 2) == 0, 32'h0000_5000 + 32'(i * 4), 32'(i), 4'hF);
        for (int k = 0; k < 5; k++) begin
            wait_ack($sformatf("t3_%0d", k), ack, rd, rs);
            if (k == 4) req_valid = '0;
            check($sformatf("t3_grant%0d", k), ack, 4'(1) << ord[k]);
        end
        r_last_cfg = 1'b1;
        check("t3_beats", {8'(aw_beats), 8'(w_beats), 8'(ar_beats)}, {8'd3, 8'd3, 8'd2});

        // async reset during a stalled read
        clr_mon();
        ar_dly = 100;
        set_req(2, 1'b0, 32'h0000_6000, '0, '0);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge aclk);
            seen = arvalid;
        end
        check("t6_arvalid_up", seen, 1'b1);
        aresetn = 0;
        #1;
        check("t6_async_clear", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
        req_valid = '0;
        any_ack = 1'b0;
        repeat (3) begin
            @(negedge aclk);
            any_ack = any_ack | (|req_ack);
        end
        aresetn = 1;
        ar_dly = 0;
        repeat (2) begin
            @(negedge aclk);
            any_ack = any_ack | (|req_ack);
        end
        check("t6_no_ack", any_ack, 1'b0);
        r_data_cfg = 32'h0000_00A0;
        set_req(1, 1'b0, 32'h0000_6010, '0, '0);
        set_req(0, 1'b0, 32'h0000_6000, '0, '0);
        wait_ack("t6a", ack, rd, rs);
        req_valid[0] = 1'b0;
        check("t6_ptr_reset_grant", ack, 4'b0001);
        wait_ack("t6b", ack, rd, rs);
        req_valid[1] = 1'b0;
        check("t6_second_grant", ack, 4'b0010);

        repeat (3) @(negedge aclk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
